// File: rtl/axis_dst_packer.sv
// axis_dst_packer: packs LANE_W result words into BUS_W AXI-Stream beats,
// with framing (TLAST/TSTRB) derived from a per-frame word count.
module axis_dst_packer #(
  parameter int BUS_W      = 64,
  parameter int LANE_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  input  logic [LANE_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  M_AXIS_TVALID,
  output logic [BUS_W-1:0]      M_AXIS_TDATA,
  output logic [BUS_W/8-1:0]    M_AXIS_TSTRB,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  busy,
  output logic                  done
);
  localparam int LANES = BUS_W / LANE_W;
  localparam int SB    = BUS_W / 8;
  localparam int LB    = LANE_W / 8;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [LEN_W-1:0]  remain;
  logic [LW-1:0]     lidx;
  logic [BUS_W-1:0]  pack_data, beat_data;
  logic [SB-1:0]     pack_strb, beat_strb;
  logic [BUS_W-1:0]  mem_data [FIFO_DEPTH];
  logic [SB-1:0]     mem_strb [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              accept, push, pop, fifo_full, last_word;

  // Full is judged on the registered count so in_ready never depends on TREADY.
  assign fifo_full     = count == (AW+1)'(FIFO_DEPTH);
  assign in_ready      = state == RUN && !fifo_full;
  assign accept        = in_valid && in_ready;
  assign last_word     = remain == LEN_W'(1);
  assign push          = accept && (lidx == LW'(LANES - 1) || last_word);
  assign M_AXIS_TVALID = count != '0;
  assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
  assign busy          = state != IDLE;
  assign beat_data     = pack_data | (BUS_W'(in_data) << (lidx * LANE_W));
  assign beat_strb     = pack_strb | (SB'({LB{1'b1}}) << (lidx * LB));
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? mem_data[rd_ptr] : '0;
  assign M_AXIS_TSTRB  = M_AXIS_TVALID ? mem_strb[rd_ptr] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && mem_last[rd_ptr];

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) begin
      state     <= IDLE;
      remain    <= '0;
      lidx      <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (len != '0) begin
            state     <= RUN;
            remain    <= len;
            lidx      <= '0;
            pack_data <= '0;
            pack_strb <= '0;
          end else done <= 1'b1;
        end
        RUN: if (accept) begin
          remain    <= remain - LEN_W'(1);
          lidx      <= push ? '0 : lidx + LW'(1);
          pack_data <= push ? '0 : beat_data;
          pack_strb <= push ? '0 : beat_strb;
          if (last_word) state <= DRAIN;
        end
        DRAIN: if (pop && count == (AW+1)'(1)) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN)
    if (!AXIS_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end

  always_ff @(posedge AXIS_ACLK)
    if (push) begin
      mem_data[wr_ptr] <= beat_data;
      mem_strb[wr_ptr] <= beat_strb;
      mem_last[wr_ptr] <= last_word;
    end
endmodule

// File: tb/tb_axis_dst_packer.sv
// tb_axis_dst_packer: randomized scoreboard bench; expected beats come from
// chunking each frame's word list into LANES-wide groups.
module tb_axis_dst_packer;
  localparam int BUS_W = 64, LANE_W = 32, FIFO_DEPTH = 4, LEN_W = 12;
  localparam int LANES = BUS_W / LANE_W, SB = BUS_W / 8, LB = LANE_W / 8;

  typedef struct {
    logic [BUS_W-1:0] data;
    logic [SB-1:0]    strb;
    logic             last;
  } beat_t;

  logic clk = 0, rst_n = 1, start = 0, in_valid = 0, tready = 0;
  logic [LEN_W-1:0]  len = '0;
  logic [LANE_W-1:0] in_data = '0;
  logic in_ready, tvalid, tlast, busy, done;
  logic [BUS_W-1:0] tdata;
  logic [SB-1:0]    tstrb;

  int checks = 0, failures = 0, tready_mode = 0, widx = 0;
  beat_t sb[$];
  logic [LANE_W-1:0] words[$];

  axis_dst_packer #(.BUS_W(BUS_W), .LANE_W(LANE_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    tready = tready_mode == 0 ? 1'b1 : tready_mode == 2 ? 1'b0 : 1'($urandom_range(1));
  end

  // Monitor: expected done/busy tracked from observed start and last-beat handshakes.
  logic mb = 0, pend = 0, prev_stall = 0, np, set_b, clr_b;
  logic [BUS_W-1:0] pdata;
  beat_t em;
  always @(negedge clk) begin
    if (!rst_n) begin
      mb = 0; pend = 0; prev_stall = 0;
    end else begin
      chk("done", done, pend);
      chk("busy", busy, mb);
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, pdata);
      end
      if (!tvalid) begin
        chk("idle_data", tdata, 0);
        chk("idle_strb_last", {tstrb, tlast}, 0);
      end
      np = 0; set_b = 0; clr_b = 0;
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", tdata);
        end else begin
          em = sb.pop_front();
          chk("beat_data", tdata, em.data);
          chk("beat_strb", tstrb, em.strb);
          chk("beat_last", tlast, em.last);
        end
        if (tlast) begin np = 1; clr_b = 1; end
      end
      if (!mb && start) begin
        if (len != 0) set_b = 1; else np = 1;
      end
      if (clr_b) mb = 0;
      if (set_b) mb = 1;
      pend = np;
      prev_stall = tvalid && !tready;
      pdata = tdata;
    end
  end

  task automatic start_frame(input int n, input bit rnd);
    if (rnd) begin
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(LANE_W'($urandom()));
    end
    widx = 0;
    for (int b = 0; b * LANES < n; b++) begin
      beat_t e;
      e.data = '0; e.strb = '0;
      for (int k = 0; k < LANES; k++)
        if (b * LANES + k < n) begin
          e.data[k*LANE_W +: LANE_W] = words[b*LANES + k];
          e.strb[k*LB +: LB] = '1;
        end
      e.last = (b + 1) * LANES >= n;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1; len = LEN_W'(n);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic feed(input int max_c, input int vprob, input bit inj, input int stop);
    for (int c = 0; c < max_c && widx < stop; c++) begin
      in_valid = $urandom_range(99) < vprob;
      in_data = words[widx];
      if (inj && c == 2) begin start = 1; len = LEN_W'(6); end
      @(negedge clk);
      if (in_valid && in_ready) widx++;
      @(posedge clk); #1;
      start = 0;
    end
    in_valid = 0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++; failures++;
    $display("FAIL done_timeout: got no done expected done within 300 cycles");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_strb_last", {tstrb, tlast}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // basic full frame
    words = '{32'd1, 32'd2, 32'd3, 32'd4};
    start_frame(4, 0); feed(50, 100, 0, 4); wait_done();
    // partial final beat
    words = '{32'hA, 32'hB, 32'hC};
    start_frame(3, 0); feed(50, 100, 0, 3); wait_done();
    // back-pressure fills the FIFO
    tready_mode = 2;
    start_frame(12, 1); feed(20, 100, 0, 12);
    chk("bp_accepted", widx, 8);
    chk("bp_in_ready", in_ready, 0);
    tready_mode = 0;
    feed(200, 100, 0, 12); wait_done();
    // zero-length frame
    start_frame(0, 1); wait_done();
    // reset mid-frame, then a clean frame
    start_frame(10, 1); feed(50, 100, 0, 5);
    rst_n = 0;
    #1;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_strb_last", {tstrb, tlast}, 0);
    chk("mid_rst_ready_busy_done", {in_ready, busy, done}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    start_frame(2, 1); feed(50, 100, 0, 2); wait_done();
    // start during RUN must be ignored
    start_frame(4, 1); feed(50, 100, 1, 4); wait_done();
    // randomized frames with random gaps and back-pressure
    tready_mode = 1;
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(9) == 0 ? 0 : $urandom_range(17, 1);
      start_frame(n, 1); feed(1000, 60, 0, n); wait_done();
    end
    tready_mode = 0;
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
